// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default widths, packed field offsets,
// control bit indices and the skid-buffer state encoding.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 4;

  // Payload field offsets (LSB positions) when a stage packs several fields
  localparam int IFID_PC_OFS          = 0;
  localparam int EXMEM_ALU_RESULT_OFS = 0;
  localparam int EXMEM_RD_ADDR_OFS    = 32;
  localparam int MEMWB_RD_DATA_OFS    = 0;
  localparam int MEMWB_RD_ADDR_OFS    = 32;
  localparam int RD_ADDR_W            = 5;

  // Control bundle bit indices
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer and occupancy FSM for pipe_stage_reg; state is
// registered, so the ready derived from it has no combinational input path.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output skid_state_e       state,
  output logic [DATA_W-1:0] skid_data,
  output logic [CTRL_W-1:0] skid_ctrl
);

  skid_state_e state_nxt;
  logic        skid_ld;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    skid_ld   = 1'b0;
    case (state)
      EMPTY: if (push) state_nxt = FULL;
      FULL: begin
        if (push && !pop) begin
          state_nxt = SKID;
          skid_ld   = 1'b1;
        end else if (!push && pop) begin
          state_nxt = EMPTY;
        end
      end
      SKID:    if (pop) state_nxt = FULL;
      default: state_nxt = EMPTY;
    endcase
    if (flush_i) begin
      state_nxt = EMPTY;
      skid_ld   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (skid_ld) begin
      skid_data <= data_i;
      skid_ctrl <= ctrl_i;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, stall hold, flush-to-bubble and a
// saturating stall counter. Define PIPE_SKID_EN for a skid entry and registered ready_o.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              ld;
  logic              ld_vld;
  logic [DATA_W-1:0] ld_data;
  logic [CTRL_W-1:0] ld_ctrl;

`ifdef PIPE_SKID_EN
  skid_state_e       state;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              push;
  logic              pop;

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i & ~stall_i;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .push      (push),
    .pop       (pop),
    .data_i    (data_i),
    .ctrl_i    (ctrl_i),
    .state     (state),
    .skid_data (skid_data),
    .skid_ctrl (skid_ctrl)
  );

  // An empty stage always loads, even under stall, so state tracks valid_o
  assign ready_o = (state != SKID);
  assign ld      = (state == EMPTY) | pop;
  assign ld_vld  = (state == SKID) | valid_i;
  assign ld_data = (state == SKID) ? skid_data : data_i;
  assign ld_ctrl = (state == SKID) ? skid_ctrl : ctrl_i;
`else
  assign ld      = ~stall_i & (~valid_o | ready_i);
  assign ready_o = ld;
  assign ld_vld  = valid_i;
  assign ld_data = data_i;
  assign ld_ctrl = ctrl_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      ctrl_o  <= '0;
    end else begin
      if (ld) data_o <= ld_data;
      if (flush_i) begin
        valid_o <= 1'b0;
        ctrl_o  <= '0;
      end else if (ld) begin
        valid_o <= ld_vld;
        ctrl_o  <= ld_vld ? ld_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (valid_o && (stall_i || !ready_i) && !flush_i && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random
// traffic compared against a queue-based transaction model.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i, valid_i, ready_o, stall_i, flush_i, valid_o, ready_i;
  logic [DW-1:0] data_i, data_o;
  logic [CW-1:0] ctrl_i, ctrl_o;
  logic [NW-1:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .ctrl_i      (ctrl_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .ctrl_o      (ctrl_o),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  item_t q[$];  // items currently held by the stage, oldest first
  int    m_cnt;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_rdy();
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return !stall_i && (q.size() == 0 || ready_i);
`endif
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic s, input logic f, input logic r, input logic rs);
    valid_i = v; data_i = d; ctrl_i = c; stall_i = s; flush_i = f; ready_i = r; rst_i = rs;
  endtask

  // One clock: check ready_o, advance the model at the edge, check outputs.
  task automatic cycle();
    logic  r;
    logic  was_rst;
    item_t it;
    #1;
    r = model_rdy();
    if (!rst_i) check("ready_o", ready_o, r);
    was_rst = rst_i;
    it.d = data_i;
    it.c = ctrl_i;
    @(posedge clk_i);
    if (rst_i) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (q.size() > 0 && (stall_i || !ready_i) && !flush_i && m_cnt < CNT_MAX) m_cnt++;
      if (flush_i) begin
        q.delete();
      end else begin
`ifdef PIPE_SKID_EN
        if (q.size() > 0 && ready_i && !stall_i) void'(q.pop_front());
        if (valid_i && r) q.push_back(it);
`else
        if (r) begin
          q.delete();
          if (valid_i) q.push_back(it);
        end
`endif
      end
    end
    #1;
    check("valid_o", valid_o, q.size() > 0);
    if (q.size() > 0) begin
      check("data_o", data_o, q[0].d);
      check("ctrl_o", ctrl_o, q[0].c);
    end else begin
      check("ctrl_o_bubble", ctrl_o, 0);
    end
    check("stall_cnt_o", stall_cnt_o, m_cnt);
    if (was_rst) check("data_o_reset", data_o, 0);
  endtask

  initial begin
    logic [DW-1:0] vals [3];
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    m_cnt = 0;

    // Reset state
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    cycle();

    // Streaming
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      check("stream_data", data_o, vals[i]);
      check("stream_ctrl", ctrl_o, 4'b1011);
      check("stream_cnt", stall_cnt_o, 0);
    end

    // Stall hold: output holds 0x20 while 0x30 waits upstream
    drive(1'b1, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 32'h10, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 32'h20, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle();
      check("stall_hold_data", data_o, 32'h20);
    end
    check("stall_cnt3", stall_cnt_o, 3);
    drive(1'b1, 32'h30, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    check("stall_release_data", data_o, 32'h30);
    check("stall_release_ctrl", ctrl_o, 4'b0110);

    // Flush wins over stall
    drive(1'b1, 32'h44, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    check("flush_valid", valid_o, 0);
    check("flush_ctrl", ctrl_o, 0);

    // Bubble
    drive(1'b0, 32'h55, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    check("bubble_valid", valid_o, 0);
    check("bubble_ctrl", ctrl_o, 0);

    // Backpressure: two items offered while ready_i=0
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 32'hA1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hB2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("bp_first", data_o, 32'hA1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
    end

    // Saturation and reset mid-hold
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 32'hC3, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("cnt_saturated", stall_cnt_o, CNT_MAX);
    drive(1'b1, 32'hD4, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ctrl", ctrl_o, 0);
    check("rst_cnt", stall_cnt_o, 0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, CW'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: the generalised successor to the fixed-field stage registers between the CPU pipeline stages. It carries a DATA_W-bit payload and a CTRL_W-bit control bundle with a valid/ready handshake, legacy stall hold, flush-to-bubble and a saturating stall-cycle counter. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The upstream stage packs its fields (pc, ALU result, rd address, RegWrite/MemToReg/MemRead/MemWrite, ...) into data_i/ctrl_i.

## Interface
Reset is synchronous and active-high. There is one clock, clk_i, and reset is rst_i.

Parameters:
- DATA_W, 32: payload width; data bits are never cleared by bubbles.
- CTRL_W, 4: control width; cleared to 0 on reset, flush and bubble.
- CNT_W, 16: stall counter width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  upstream item valid.
- ready_o  out  1  stage can accept this cycle.
- data_i  in  DATA_W  upstream payload.
- ctrl_i  in  CTRL_W  upstream control bits.
- stall_i  in  1  hazard-unit hold; freezes the stage.
- flush_i  in  1  branch/exception squash of the stage contents.
- valid_o  out  1  output item valid.
- ready_i  in  1  downstream accepts.
- data_o  out  DATA_W  registered payload.
- ctrl_o  out  CTRL_W  registered control; 0 whenever valid_o=0.
- stall_cnt_o  out  CNT_W  saturating count of held cycles.

## Operation
- **Transfers.**
  - Upstream transfer: valid_i & ready_o.
  - Downstream transfer: valid_o & ready_i.
- **Load condition.** The output register loads when `ld = ~stall_i & (~valid_o | ready_i)`.
- **On ld:**
  - valid_o <= valid_i.
  - data_o <= data_i.
  - ctrl_o <= valid_i ? ctrl_i : 0 (bubble).
- **Hold.** When ld=0, all outputs hold their values.
- **Flush.** flush_i=1 forces valid_o<=0 and ctrl_o<=0 next edge. It also empties the skid entry when present.
  - Flush wins over stall_i and over a simultaneous load.
  - data_o is don't-care after a flush, but is in fact loaded if ld=1.
- **Stall counter.** stall_cnt_o increments when valid_o & (stall_i | ~ready_i) & ~flush_i.
  - Saturates at 2^CNT_W-1; it does not wrap.
  - Cleared only by rst_i.
- **Reset.** rst_i=1 forces valid_o=0, ctrl_o=0, data_o=0, stall_cnt_o=0 and skid empty.
  - rst_i has priority over flush_i, stall_i and all loads.
  - Mid-operation, any held or skid item is discarded.
- **Inputs while ready_o=0.** Undefined data/ctrl on valid_i while ready_o=0 must not affect state.

## Timing
- Latency is 1 cycle from upstream transfer to valid_o, in the empty-stage case.
- Without skid: ready_o = ~stall_i & (~valid_o | ready_i). This is combinational from ready_i and stall_i.
- Full-throughput streaming is 1 item/cycle with ready_i held high.
- The first edge after rst_i deasserts may accept an item. ready_o is valid during reset but ignored.

## Configuration
- **PIPE_SKID_EN defined:** a one-entry skid buffer is inserted and ready_o is registered (ready_o = ~skid_full). There is no combinational ready_i->ready_o path.
  - States are EMPTY (valid_o=0), FULL (valid_o=1, skid empty) and SKID (valid_o=1, skid full).
  - EMPTY->FULL on upstream transfer.
  - FULL->SKID on upstream transfer while the output is blocked (~ready_i | stall_i).
  - FULL->EMPTY on downstream transfer with no upstream transfer.
  - SKID->FULL on downstream transfer: the skid entry moves to the output and ready_o rises on the next cycle.
  - flush_i from any state goes to EMPTY.
  - Latency is unchanged at 1 cycle. Throughput is 1 item/cycle.
- **PIPE_SKID_EN undefined:** behaviour is exactly as in Operation/Timing, with no skid storage.

## Structure
- Shared package pipe_pkg:
  - Default widths PIPE_DATA_W=32 and PIPE_CTRL_W=4.
  - Per-stage packed field offsets (pc, alu_result, rd_data, rd_addr; RegWrite/MemToReg/MemRead/MemWrite bit indices).
  - The skid state enum {EMPTY, FULL, SKID}.
- Sub-module pipe_skid_buf holds the optional skid entry. It is instantiated only under PIPE_SKID_EN.

## Test plan
- **Streaming.** Reset, ready_i=1, stall_i=0; drive data_i=0x10,0x20,0x30 with ctrl_i=4'b1011 for 3 cycles -> valid_o and data_o follow 1 cycle later; ctrl_o=4'b1011; stall_cnt_o=0.
- **Stall hold.** Output holds data_o=0x20; assert stall_i for 3 cycles -> data_o stays 0x20, ready_o=0, stall_cnt_o=3; deassert -> the next item loads.
- **Flush precedence.** Assert flush_i and stall_i together with valid_o=1 -> next cycle valid_o=0, ctrl_o=0.
- **Bubble.** Drive valid_i=0 on a load cycle with ctrl_i=4'hF -> ctrl_o=0, valid_o=0.
- **Backpressure with PIPE_SKID_EN.**
  - ready_i=0 with two items offered -> first in data_o, second in skid, ready_o=0.
  - ready_i=1 -> items emerge in order on consecutive cycles, then ready_o=1.
  - Without the macro: only the first item is accepted.
- **Reset and saturation.**
  - CNT_W=4, ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15.
  - rst_i mid-hold -> all outputs 0 on the next edge and the skid is empty.
